// File: rtl/freq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : freq_ctrl_pkg
// Description : Shared definitions for the frequency-lock sequencer: FSM
//               state encoding, default tuning parameters and a small
//               unsigned absolute-difference helper.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // Defaults; all four must fit in 8 bits.
  localparam int unsigned LOCK_COUNT_DEF  = 4;
  localparam int unsigned MAX_UPDATES_DEF = 64;
  localparam int unsigned DELTA_DEF       = 2;
  localparam int unsigned SETTLE_DEF      = 3;

  // |a - b| as a 9-bit unsigned value.
  function automatic logic [8:0] abs_diff9(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, b} - {1'b0, a};
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psi_update_strobe.sv
`default_nettype none
// ============================================================================
// Module      : psi_update_strobe
// Description : Detects falling edges of psi and emits a one-cycle sample
//               strobe SETTLE cycles later. A new edge restarts the delay.
// Ports       : clk, rst      - clock, async active-high reset
//               i_psi         - measured pulse
//               i_cancel      - drop any pending sample
//               o_strobe      - sample adjusteddiv on this rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module psi_update_strobe
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_psi,
  input  logic i_cancel,
  output logic o_strobe
);

  localparam logic [7:0] c_SETTLE = 8'(SETTLE);

  logic       r_psi_d;
  logic [7:0] r_cnt;
  logic       w_fall;

  assign w_fall = r_psi_d & ~i_psi;

  // The edge is registered when w_fall is sampled; the count then reaches 1
  // one cycle before the sampling edge, SETTLE edges after detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psi_d <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_psi_d <= i_psi;
      if (i_cancel)          r_cnt <= 8'd0;
      else if (w_fall)       r_cnt <= c_SETTLE;
      else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
    end
  end

  // A coincident new edge supersedes the expiring one.
  assign o_strobe = (r_cnt == 8'd1) && !w_fall && !i_cancel;

endmodule
`default_nettype wire

// File: rtl/freq_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : freq_lock_sequencer
// Description : Sequences a divider regulator: resets it, waits for its
//               divider output to settle to a stable value, declares lock and
//               monitors drift, flagging rail or timeout faults.
// Ports       : clk, rst        - clock, async active-high reset
//               start, stop     - single-cycle control requests
//               target_period   - desired psi high time (clk cycles)
//               psi             - measured pulse
//               adjusteddiv     - divider reported by the regulator
//               setperiod       - period driven to the regulator
//               reg_rst         - regulator reset pulse
//               locked, fault, busy - status
//               lock_div        - divider captured at lock
//               unlock_cnt      - saturating count of lock losses
// Revision    : 1.0 - initial release
// ============================================================================
module freq_lock_sequencer
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int unsigned MAX_UPDATES = MAX_UPDATES_DEF,
  parameter int unsigned DELTA       = DELTA_DEF,
  parameter int unsigned SETTLE      = SETTLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] target_period,
  input  logic       psi,
  input  logic [7:0] adjusteddiv,
  output logic [7:0] setperiod,
  output logic       reg_rst,
  output logic       locked,
  output logic       fault,
  output logic       busy,
  output logic [7:0] lock_div,
  output logic [3:0] unlock_cnt
);

  localparam logic [7:0] c_LOCK_COUNT  = 8'(LOCK_COUNT);
  localparam logic [7:0] c_MAX_UPDATES = 8'(MAX_UPDATES);
  localparam logic [8:0] c_DELTA       = 9'(DELTA);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_clr_cnt;
  logic [7:0] r_prev;
  logic       r_have_prev;
  logic [7:0] r_stable_cnt;
  logic [7:0] r_upd_cnt;
  logic [7:0] r_setperiod;
  logic       r_reg_rst, r_locked, r_fault, r_busy;
  logic [7:0] r_lock_div;
  logic [3:0] r_unlock_cnt;

  logic       w_strobe, w_sample, w_rail, w_match, w_lock_hit, w_timeout, w_drift;
  logic       w_enter_clear;
  logic [7:0] w_stable_inc, w_upd_inc;

  psi_update_strobe #(.SETTLE(SETTLE)) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .i_psi    (psi),
    .i_cancel (stop),
    .o_strobe (w_strobe)
  );

  assign w_sample     = w_strobe && (r_state == ST_ACQUIRE || r_state == ST_LOCKED);
  assign w_rail       = (adjusteddiv == 8'h00) || (adjusteddiv == 8'hFF);
  assign w_match      = r_have_prev && (adjusteddiv == r_prev);
  assign w_stable_inc = r_stable_cnt + 8'd1;
  assign w_upd_inc    = r_upd_cnt + 8'd1;
  assign w_lock_hit   = w_match && (w_stable_inc == c_LOCK_COUNT);
  assign w_timeout    = (w_upd_inc == c_MAX_UPDATES);
  assign w_drift      = abs_diff9(adjusteddiv, r_lock_div) > c_DELTA;

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_FAULT: if (start) w_state_nxt = ST_CLEAR;
        ST_CLEAR:          if (r_clr_cnt) w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          // Rail beats lock; lock beats timeout.
          if (w_sample) begin
            if (w_rail)          w_state_nxt = ST_FAULT;
            else if (w_lock_hit) w_state_nxt = ST_LOCKED;
            else if (w_timeout)  w_state_nxt = ST_FAULT;
          end
        end
        ST_LOCKED:         if (w_sample && w_drift) w_state_nxt = ST_ACQUIRE;
        default:           w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_enter_clear = (w_state_nxt == ST_CLEAR) && (r_state != ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_clr_cnt    <= 1'b0;
      r_prev       <= 8'h00;
      r_have_prev  <= 1'b0;
      r_stable_cnt <= 8'd0;
      r_upd_cnt    <= 8'd0;
      r_setperiod  <= 8'h00;
      r_reg_rst    <= 1'b0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_busy       <= 1'b0;
      r_lock_div   <= 8'h00;
      r_unlock_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      // Status flags are decoded from the next state so they track r_state.
      r_reg_rst <= (w_state_nxt == ST_CLEAR);
      r_locked  <= (w_state_nxt == ST_LOCKED);
      r_fault   <= (w_state_nxt == ST_FAULT);
      r_busy    <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_ACQUIRE) ||
                   (w_state_nxt == ST_LOCKED);
      r_clr_cnt <= (r_state == ST_CLEAR) && (w_state_nxt == ST_CLEAR);

      if (w_enter_clear) begin
        r_setperiod  <= target_period;
        r_unlock_cnt <= 4'd0;
        r_stable_cnt <= 8'd0;
        r_upd_cnt    <= 8'd0;
        r_have_prev  <= 1'b0;
      end

      if (w_sample && !stop) begin
        if (r_state == ST_ACQUIRE) begin
          r_upd_cnt    <= w_upd_inc;
          r_prev       <= adjusteddiv;
          r_have_prev  <= 1'b1;
          r_stable_cnt <= w_match ? w_stable_inc : 8'd0;
          if (w_state_nxt == ST_LOCKED) r_lock_div <= adjusteddiv;
        end else if (w_state_nxt == ST_ACQUIRE) begin
          // Lock lost: the out-of-tolerance sample becomes the new reference.
          r_upd_cnt    <= 8'd0;
          r_stable_cnt <= 8'd0;
          r_prev       <= adjusteddiv;
          r_have_prev  <= 1'b1;
          if (r_unlock_cnt != 4'hF) r_unlock_cnt <= r_unlock_cnt + 4'd1;
        end
      end
    end
  end

  assign setperiod  = r_setperiod;
  assign reg_rst    = r_reg_rst;
  assign locked     = r_locked;
  assign fault      = r_fault;
  assign busy       = r_busy;
  assign lock_div   = r_lock_div;
  assign unlock_cnt = r_unlock_cnt;

endmodule
`default_nettype wire

// File: doc/freq_lock_sequencer.md
FREQ_LOCK_SEQUENCER -- requirements
Module: freq_lock_sequencer

Interface
REQ-001 Parameter LOCK_COUNT, 4: consecutive stable updates required to declare lock.
REQ-002 Parameter MAX_UPDATES, 64: updates allowed in ACQUIRE before timeout fault.
REQ-003 Parameter DELTA, 2: maximum |adjusteddiv - lock_div| tolerated while LOCKED.
REQ-004 Parameter SETTLE, 3: clk cycles from a detected psi falling edge to the adjusteddiv sample.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin acquisition; ignored outside IDLE and FAULT.
REQ-008 stop  input  1  single-cycle request to return to IDLE from any state.
REQ-009 target_period  input  8  desired psi high duration, in clk cycles.
REQ-010 psi  input  1  measured pulse, the same signal fed to the regulator.
REQ-011 adjusteddiv  input  8  divider value reported by the regulator.
REQ-012 setperiod  output  8  registered period driven to the regulator.
REQ-013 reg_rst  output  1  registered reset pulse to the regulator.
REQ-014 locked  output  1  high only in LOCKED.
REQ-015 fault  output  1  high only in FAULT.
REQ-016 busy  output  1  high in CLEAR, ACQUIRE and LOCKED.
REQ-017 lock_div  output  8  adjusteddiv value captured at the lock declaration.
REQ-018 unlock_cnt  output  4  saturating count of LOCKED-to-ACQUIRE transitions since the last start.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, ACQUIRE, LOCKED and FAULT.
REQ-020 IDLE->CLEAR on start; CLEAR SHALL last exactly 2 cycles with reg_rst=1, then go to ACQUIRE.
REQ-021 On entry to CLEAR, setperiod SHALL load target_period, and setperiod SHALL hold that value until the next entry to CLEAR.
REQ-022 A psi falling edge SHALL be detected with one registered copy of psi; the update sample SHALL occur SETTLE cycles after detection.
REQ-023 An edge detected while an earlier sample is still pending SHALL restart the SETTLE delay, so only one sample is taken.
REQ-024 In ACQUIRE, each sample equal to the previous sample SHALL increment stable_cnt; an unequal sample SHALL set stable_cnt to 0.
REQ-025 In ACQUIRE, the first sample after CLEAR SHALL only initialise the previous-sample register and SHALL leave stable_cnt at 0.
REQ-026 When stable_cnt reaches LOCK_COUNT, the FSM SHALL go ACQUIRE->LOCKED and lock_div SHALL capture that sample.
REQ-027 In ACQUIRE, a sample equal to 8'h00 or 8'hFF SHALL cause ACQUIRE->FAULT (divider rail).
REQ-028 In ACQUIRE, the update counter reaching MAX_UPDATES without lock SHALL cause ACQUIRE->FAULT (timeout).
REQ-029 In LOCKED, a sample with |sample - lock_div| > DELTA, computed as a 9-bit unsigned difference, SHALL cause LOCKED->ACQUIRE.
REQ-030 On LOCKED->ACQUIRE, stable_cnt and the update counter SHALL clear and unlock_cnt SHALL increment, saturating at 15.
REQ-031 FAULT SHALL hold until start (->CLEAR) or stop (->IDLE).
REQ-032 stop SHALL take priority over start and over every sample-driven transition in the same cycle.
REQ-033 stop SHALL force IDLE from any state, including CLEAR, and SHALL cancel any pending sample.
REQ-034 When both rail and lock conditions hold on the same sample, FAULT SHALL win.
REQ-035 Every output SHALL be registered and SHALL reflect the new state in the cycle after the transition.
REQ-036 unlock_cnt SHALL clear on start.

Reset
REQ-037 Reset SHALL force state=IDLE, setperiod=8'h00, reg_rst=0, locked=0, fault=0, busy=0, lock_div=8'h00, unlock_cnt=0, all internal counters to 0 and the psi edge register to 0.

Structure
REQ-038 The state encoding and the default values of LOCK_COUNT, MAX_UPDATES, DELTA and SETTLE SHALL live in the shared package freq_ctrl_pkg.
REQ-039 A single sub-module, psi_update_strobe, SHALL contain the falling-edge detection and the SETTLE delay and SHALL emit a one-cycle sample strobe.

Verification
REQ-040 target_period=10, adjusteddiv held at 8'h80, psi pulses every 20 cycles, start -> reg_rst high for 2 cycles; locked=1 after the 5th sample; lock_div=8'h80.
REQ-041 In LOCKED with lock_div=8'h80, adjusteddiv steps to 8'h82 -> stays LOCKED; then to 8'h83 -> ACQUIRE and unlock_cnt=1.
REQ-042 In ACQUIRE, adjusteddiv toggles between 8'h40 and 8'h41 on every sample -> fault=1 after 64 samples.
REQ-043 In ACQUIRE, adjusteddiv=8'hFF at a sample, with the lock condition also met -> fault=1 and locked=0.
REQ-044 stop asserted during the second CLEAR cycle, together with start -> IDLE next cycle, reg_rst=0, busy=0.
REQ-045 rst asserted asynchronously mid-LOCKED -> all outputs at their reset values immediately, without waiting for a clk edge.
